// File: rtl/reorder_buffer_pkg.sv
// Shared reorder-buffer constants and entry layout, used by the ROB, register file,
// decoder and reservation stations.
package reorder_buffer_pkg;

   localparam int ROB_DEPTH_LOG2 = 4;
   localparam int ROB_DEPTH      = 1 << ROB_DEPTH_LOG2;
   localparam int ROB_TAG_W      = ROB_DEPTH_LOG2;
   localparam int ROB_RD_W       = 5;
   localparam int ROB_DATA_W     = 32;

   typedef struct packed {
      logic                  valid;
      logic                  done;
      logic [ROB_RD_W-1:0]   rd;
      logic [ROB_DATA_W-1:0] value;
      logic                  is_br;
      logic                  pred_taken;
      logic                  taken;
      logic [ROB_DATA_W-1:0] target;
   } rob_entry_t;

   function automatic logic rob_is_mispredict(input rob_entry_t e);
      return e.is_br && (e.taken != e.pred_taken);
   endfunction

endpackage

// File: rtl/reorder_buffer.sv
// 16-entry in-order-retire reorder buffer with branch rollback.
// Build option ROB_QUERY_BYPASS_EN forwards a same-cycle writeback to the operand queries.
module reorder_buffer
   import reorder_buffer_pkg::*;
#(
   parameter int DEPTH_LOG2 = ROB_DEPTH_LOG2
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  rdy,
   input  logic                  issue_valid,
   input  logic [4:0]            issue_rd,
   input  logic                  issue_is_br,
   input  logic                  issue_pred_taken,
   output logic                  alloc_ready,
   output logic [DEPTH_LOG2-1:0] alloc_id,
   input  logic                  wb_valid,
   input  logic [DEPTH_LOG2-1:0] wb_id,
   input  logic [31:0]           wb_value,
   input  logic                  wb_taken,
   input  logic [31:0]           wb_target,
   input  logic [DEPTH_LOG2-1:0] q1_id,
   input  logic [DEPTH_LOG2-1:0] q2_id,
   output logic                  q1_ready,
   output logic                  q2_ready,
   output logic [31:0]           q1_val,
   output logic [31:0]           q2_val,
   output logic                  commit_valid,
   output logic [4:0]            commit_rd,
   output logic [31:0]           commit_val,
   output logic [DEPTH_LOG2-1:0] commit_id,
   output logic                  rollback,
   output logic [31:0]           rollback_pc
);

   localparam int DEPTH = 1 << DEPTH_LOG2;
   localparam logic [DEPTH_LOG2:0] FULL_COUNT = (DEPTH_LOG2+1)'(DEPTH);

   rob_entry_t            entries_q [DEPTH];
   rob_entry_t            entries_d [DEPTH];
   logic [DEPTH_LOG2-1:0] head_q, head_d, tail_q, tail_d;
   logic [DEPTH_LOG2:0]   count_q, count_d;
   logic                  commit_valid_q, commit_valid_d;
   logic [4:0]            commit_rd_q, commit_rd_d;
   logic [31:0]           commit_val_q, commit_val_d;
   logic [DEPTH_LOG2-1:0] commit_id_q, commit_id_d;
   logic                  rollback_q, rollback_d;
   logic [31:0]           rollback_pc_q, rollback_pc_d;
   rob_entry_t            head_e;
   logic                  do_retire, do_alloc, do_wb;

   assign alloc_ready  = (count_q != FULL_COUNT) && !rollback_q;
   assign alloc_id     = tail_q;
   assign commit_valid = commit_valid_q;
   assign commit_rd    = commit_rd_q;
   assign commit_val   = commit_val_q;
   assign commit_id    = commit_id_q;
   assign rollback     = rollback_q;
   assign rollback_pc  = rollback_pc_q;

   // Next-state: retire at head, capture writeback, allocate at tail, or flush on mispredict.
   always_comb begin
      entries_d      = entries_q;
      head_d         = head_q;
      tail_d         = tail_q;
      count_d        = count_q;
      commit_valid_d = 1'b0;
      commit_rd_d    = commit_rd_q;
      commit_val_d   = commit_val_q;
      commit_id_d    = commit_id_q;
      rollback_d     = 1'b0;
      rollback_pc_d  = rollback_pc_q;
      head_e         = entries_q[head_q];
      do_retire      = head_e.valid && head_e.done;
      do_alloc       = issue_valid && alloc_ready;
      do_wb          = wb_valid && !rollback_q && entries_q[wb_id].valid;
      if (rdy) begin
         if (do_retire) begin
            commit_valid_d = (head_e.rd != 5'd0);
            commit_rd_d    = head_e.rd;
            commit_val_d   = head_e.value;
            commit_id_d    = head_q;
         end else begin
            commit_valid_d = 1'b0;
         end
         // A mispredicted head discards everything younger, including this edge's alloc/wb.
         if (do_retire && rob_is_mispredict(head_e)) begin
            rollback_d    = 1'b1;
            rollback_pc_d = head_e.target;
            for (int i = 0; i < DEPTH; i++) begin
               entries_d[i].valid = 1'b0;
               entries_d[i].done  = 1'b0;
            end
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
         end else begin
            if (do_wb) begin
               entries_d[wb_id].done   = 1'b1;
               entries_d[wb_id].value  = wb_value;
               entries_d[wb_id].taken  = wb_taken;
               entries_d[wb_id].target = wb_target;
            end else begin
               entries_d[wb_id] = entries_q[wb_id];
            end
            if (do_retire) begin
               entries_d[head_q].valid = 1'b0;
               head_d = head_q + DEPTH_LOG2'(1);
            end else begin
               head_d = head_q;
            end
            if (do_alloc) begin
               entries_d[tail_q] = '{valid: 1'b1, done: 1'b0, rd: issue_rd, value: 32'd0,
                                     is_br: issue_is_br, pred_taken: issue_pred_taken,
                                     taken: 1'b0, target: 32'd0};
               tail_d = tail_q + DEPTH_LOG2'(1);
            end else begin
               tail_d = tail_q;
            end
            count_d = count_q + (DEPTH_LOG2+1)'(do_alloc) - (DEPTH_LOG2+1)'(do_retire);
         end
      end else begin
         commit_valid_d = 1'b0;
         rollback_d     = 1'b0;
      end
   end

   // State register with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            entries_q[i] <= '0;
         end
         head_q         <= '0;
         tail_q         <= '0;
         count_q        <= '0;
         commit_valid_q <= 1'b0;
         commit_rd_q    <= 5'd0;
         commit_val_q   <= 32'd0;
         commit_id_q    <= '0;
         rollback_q     <= 1'b0;
         rollback_pc_q  <= 32'd0;
      end else begin
         entries_q      <= entries_d;
         head_q         <= head_d;
         tail_q         <= tail_d;
         count_q        <= count_d;
         commit_valid_q <= commit_valid_d;
         commit_rd_q    <= commit_rd_d;
         commit_val_q   <= commit_val_d;
         commit_id_q    <= commit_id_d;
         rollback_q     <= rollback_d;
         rollback_pc_q  <= rollback_pc_d;
      end
   end

   // Operand tag lookups.
   always_comb begin
      q1_ready = entries_q[q1_id].done;
      q1_val   = entries_q[q1_id].value;
      q2_ready = entries_q[q2_id].done;
      q2_val   = entries_q[q2_id].value;
`ifdef ROB_QUERY_BYPASS_EN
      if (wb_valid && (wb_id == q1_id)) begin
         q1_ready = 1'b1;
         q1_val   = wb_value;
      end else begin
         q1_ready = entries_q[q1_id].done;
      end
      if (wb_valid && (wb_id == q2_id)) begin
         q2_ready = 1'b1;
         q2_val   = wb_value;
      end else begin
         q2_ready = entries_q[q2_id].done;
      end
`endif
   end

endmodule

// File: tb/tb_reorder_buffer.sv
// Scoreboard bench for reorder_buffer: expected commits are queued at issue time and
// compared as commit pulses appear.
module tb_reorder_buffer;

   typedef struct {
      logic [4:0]  rd;
      logic [31:0] val;
      logic [3:0]  id;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        rdy = 1'b1;
   logic        issue_valid = 1'b0;
   logic [4:0]  issue_rd = 5'd0;
   logic        issue_is_br = 1'b0;
   logic        issue_pred_taken = 1'b0;
   logic        alloc_ready;
   logic [3:0]  alloc_id;
   logic        wb_valid = 1'b0;
   logic [3:0]  wb_id = 4'd0;
   logic [31:0] wb_value = 32'd0;
   logic        wb_taken = 1'b0;
   logic [31:0] wb_target = 32'd0;
   logic [3:0]  q1_id = 4'd0, q2_id = 4'd0;
   logic        q1_ready, q2_ready;
   logic [31:0] q1_val, q2_val;
   logic        commit_valid;
   logic [4:0]  commit_rd;
   logic [31:0] commit_val;
   logic [3:0]  commit_id;
   logic        rollback;
   logic [31:0] rollback_pc;

   int          checks = 0;
   int          failures = 0;
   int          commit_cnt = 0;
   exp_t        sb[$];
   logic [31:0] vals [16];
   logic [3:0]  exp_tail = 4'd0;

   reorder_buffer dut (
      .clk(clk), .rst(rst), .rdy(rdy),
      .issue_valid(issue_valid), .issue_rd(issue_rd), .issue_is_br(issue_is_br),
      .issue_pred_taken(issue_pred_taken), .alloc_ready(alloc_ready), .alloc_id(alloc_id),
      .wb_valid(wb_valid), .wb_id(wb_id), .wb_value(wb_value), .wb_taken(wb_taken),
      .wb_target(wb_target), .q1_id(q1_id), .q2_id(q2_id), .q1_ready(q1_ready),
      .q2_ready(q2_ready), .q1_val(q1_val), .q2_val(q2_val), .commit_valid(commit_valid),
      .commit_rd(commit_rd), .commit_val(commit_val), .commit_id(commit_id),
      .rollback(rollback), .rollback_pc(rollback_pc)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic issue(input logic [4:0] rd, input logic br, input logic pred,
                        input logic [31:0] val, input logic push_en);
      exp_t e;
      check_eq("issue_ready", 64'(alloc_ready), 64'd1);
      check_eq("issue_id", 64'(alloc_id), 64'(exp_tail));
      issue_valid = 1'b1;
      issue_rd = rd;
      issue_is_br = br;
      issue_pred_taken = pred;
      vals[exp_tail] = val;
      if (push_en && rd != 5'd0) begin
         e.rd = rd; e.val = val; e.id = exp_tail;
         sb.push_back(e);
      end
      step();
      issue_valid = 1'b0;
      issue_is_br = 1'b0;
      exp_tail = exp_tail + 4'd1;
   endtask

   task automatic wb(input logic [3:0] id, input logic [31:0] val, input logic tk,
                     input logic [31:0] tgt);
      wb_valid = 1'b1; wb_id = id; wb_value = val; wb_taken = tk; wb_target = tgt;
      step();
      wb_valid = 1'b0;
   endtask

   task automatic wait_empty(input int bound);
      int n = 0;
      while (sb.size() != 0 && n < bound) begin
         step();
         n++;
      end
      check_eq("drain_done", 64'(sb.size()), 64'd0);
   endtask

   // Commit monitor: every pulse must match the oldest expected retirement.
   always @(negedge clk) begin
      if (!rst && commit_valid) begin
         exp_t e;
         commit_cnt++;
         if (sb.size() == 0) begin
            check_eq("commit_unexpected", 64'd1, 64'd0);
         end else begin
            e = sb.pop_front();
            check_eq("commit_rd", 64'(commit_rd), 64'(e.rd));
            check_eq("commit_val", 64'(commit_val), 64'(e.val));
            check_eq("commit_id", 64'(commit_id), 64'(e.id));
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int seen;
      exp_t e;
      repeat (2) step();
      rst = 1'b0;
      check_eq("rst_alloc_ready", 64'(alloc_ready), 64'd1);
      check_eq("rst_alloc_id", 64'(alloc_id), 64'd0);
      check_eq("rst_commit_valid", 64'(commit_valid), 64'd0);
      check_eq("rst_commit_rd", 64'(commit_rd), 64'd0);
      check_eq("rst_commit_val", 64'(commit_val), 64'd0);
      check_eq("rst_rollback", 64'(rollback), 64'd0);
      check_eq("rst_rollback_pc", 64'(rollback_pc), 64'd0);
      check_eq("rst_q1_ready", 64'(q1_ready), 64'd0);
      check_eq("rst_q1_val", 64'(q1_val), 64'd0);

      // Fill all 16 entries without writeback.
      for (int i = 0; i < 16; i++) begin
         issue(5'(i + 1), 1'b0, 1'b0, 32'h100 + 32'(i), 1'b1);
      end
      check_eq("full_not_ready", 64'(alloc_ready), 64'd0);
      issue_valid = 1'b1; issue_rd = 5'd31;
      step();
      check_eq("full_17th_ignored_ready", 64'(alloc_ready), 64'd0);
      check_eq("full_17th_ignored_id", 64'(alloc_id), 64'd0);
      // Head completes while the decoder keeps requesting.
      wb_valid = 1'b1; wb_id = 4'd0; wb_value = vals[0]; wb_taken = 1'b0;
      step();
      wb_valid = 1'b0;
      check_eq("full_wb_no_commit_yet", 64'(commit_valid), 64'd0);
      check_eq("full_wb_still_full", 64'(alloc_ready), 64'd0);
      step();
      check_eq("full_retire_commit", 64'(commit_valid), 64'd1);
      check_eq("full_retire_frees", 64'(alloc_ready), 64'd1);
      check_eq("full_freed_tag", 64'(alloc_id), 64'd0);
      e.rd = 5'd31; e.val = 32'h31F; e.id = 4'd0;
      sb.push_back(e);
      vals[0] = 32'h31F;
      step();
      issue_valid = 1'b0;
      exp_tail = 4'd1;
      check_eq("realloc_full_again", 64'(alloc_ready), 64'd0);
      check_eq("realloc_next_id", 64'(alloc_id), 64'd1);
      for (int i = 1; i < 17; i++) begin
         wb(4'(i), vals[4'(i)], 1'b0, 32'd0);
      end
      wait_empty(40);

      // Out-of-order writeback, in-order commit, then a mispredicted branch.
      rst = 1'b1;
      step();
      rst = 1'b0;
      exp_tail = 4'd0;
      issue(5'd5, 1'b0, 1'b0, 32'h11, 1'b1);
      issue(5'd6, 1'b0, 1'b0, 32'h22, 1'b1);
      issue(5'd0, 1'b1, 1'b0, 32'h0, 1'b0);
      issue(5'd9, 1'b0, 1'b0, 32'h33, 1'b0);
      wb(4'd1, 32'h22, 1'b0, 32'd0);
      wb(4'd0, 32'h11, 1'b0, 32'd0);
      check_eq("wb_commit_latency", 64'(commit_valid), 64'd0);
      wb(4'd3, 32'h33, 1'b0, 32'd0);
      check_eq("commit_first", 64'(commit_valid), 64'd1);
      wb(4'd2, 32'h0, 1'b1, 32'h1000);
      check_eq("commit_second", 64'(commit_valid), 64'd1);
      step();
      check_eq("rollback_pulse", 64'(rollback), 64'd1);
      check_eq("rollback_pc", 64'(rollback_pc), 64'h1000);
      check_eq("rollback_no_alloc", 64'(alloc_ready), 64'd0);
      check_eq("rollback_tail", 64'(alloc_id), 64'd0);
      check_eq("rollback_no_commit", 64'(commit_valid), 64'd0);
      step();
      check_eq("rollback_cleared", 64'(rollback), 64'd0);
      check_eq("after_rollback_ready", 64'(alloc_ready), 64'd1);
      check_eq("after_rollback_id", 64'(alloc_id), 64'd0);
      exp_tail = 4'd0;

      // Operand query of a fresh writeback.
      issue(5'd12, 1'b0, 1'b0, 32'hA0, 1'b1);
      issue(5'd13, 1'b0, 1'b0, 32'hA1, 1'b1);
      issue(5'd14, 1'b0, 1'b0, 32'hA2, 1'b1);
      issue(5'd15, 1'b0, 1'b0, 32'hABCD, 1'b1);
      q1_id = 4'd3; q2_id = 4'd3;
      wb_valid = 1'b1; wb_id = 4'd3; wb_value = 32'hABCD; wb_taken = 1'b0;
      #1;
`ifdef ROB_QUERY_BYPASS_EN
      check_eq("q1_bypass_ready", 64'(q1_ready), 64'd1);
      check_eq("q1_bypass_val", 64'(q1_val), 64'hABCD);
      check_eq("q2_bypass_ready", 64'(q2_ready), 64'd1);
`else
      check_eq("q1_same_cycle_ready", 64'(q1_ready), 64'd0);
      check_eq("q2_same_cycle_ready", 64'(q2_ready), 64'd0);
`endif
      step();
      wb_valid = 1'b0;
      #1;
      check_eq("q1_stored_ready", 64'(q1_ready), 64'd1);
      check_eq("q1_stored_val", 64'(q1_val), 64'hABCD);
      check_eq("q2_stored_val", 64'(q2_val), 64'hABCD);
      for (int i = 0; i < 3; i++) begin
         wb(4'(i), vals[4'(i)], 1'b0, 32'd0);
      end
      wait_empty(20);

      // Freeze with rdy low mid-stream.
      issue(5'd21, 1'b0, 1'b0, 32'hC0, 1'b1);
      issue(5'd22, 1'b0, 1'b0, 32'hC1, 1'b1);
      issue(5'd23, 1'b0, 1'b0, 32'hC2, 1'b1);
      issue(5'd24, 1'b0, 1'b0, 32'hC3, 1'b1);
      wb(4'd4, 32'hC0, 1'b0, 32'd0);
      wb(4'd5, 32'hC1, 1'b0, 32'd0);
      rdy = 1'b0;
      step();
      seen = commit_cnt;
      check_eq("freeze_commit_cleared", 64'(commit_valid), 64'd0);
      step();
      step();
      check_eq("freeze_no_commits", 64'(commit_cnt - seen), 64'd0);
      check_eq("freeze_tail", 64'(alloc_id), 64'(exp_tail));
      check_eq("freeze_commit_low", 64'(commit_valid), 64'd0);
      rdy = 1'b1;
      step();
      check_eq("resume_commit", 64'(commit_valid), 64'd1);
      wb(4'd6, 32'hC2, 1'b0, 32'd0);
      wb(4'd7, 32'hC3, 1'b0, 32'd0);
      wait_empty(20);
      check_eq("final_id", 64'(alloc_id), 64'd8);
      check_eq("final_ready", 64'(alloc_ready), 64'd1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
